// File: rtl/defines.sv
// Shared definitions for the fetch/decode front end: datapath width, queue depth and the
// {pc, instruction} record carried between fetch and decode.
package defines;

  localparam int DATA_WIDTH        = 32;
  localparam int FETCH_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode; a redirect (flush) squashes every buffered entry.
// Optional same-cycle empty-queue bypass is enabled with the FETCH_QUEUE_BYPASS_EN macro.
module fetch_queue
  import defines::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [DATA_WIDTH-1:0]        push_pc_i,
  input  logic [DATA_WIDTH-1:0]        push_instr_i,
  output logic                         pop_valid_o,
  input  logic                         pop_ready_i,
  output logic [DATA_WIDTH-1:0]        pop_pc_o,
  output logic [DATA_WIDTH-1:0]        pop_instr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  logic         empty;
  logic         full;
  logic         bypass;
  logic         push_fire;
  logic         pop_fire;
  logic         wr_en;
  logic         rd_en;
  fetch_entry_t head;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue forwards the incoming entry straight to decode unless a redirect is in flight.
  assign bypass = empty && push_valid_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  // Ready depends on occupancy only, so decode stalls never reach the PC enable combinationally.
  assign push_ready_o = !full;
  assign pop_valid_o  = !empty || bypass;
  assign head         = bypass ? fetch_entry_t'{pc: push_pc_i, instr: push_instr_i} : mem[rptr];
  assign pop_pc_o     = head.pc;
  assign pop_instr_o  = head.instr;
  assign count_o      = count;

  assign push_fire = push_valid_i && !full;
  assign pop_fire  = pop_valid_o && pop_ready_i;
  // A bypassed entry that decode takes immediately never touches storage or pointers.
  assign wr_en     = push_fire && !(bypass && pop_ready_i);
  assign rd_en     = pop_fire && !bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr] <= fetch_entry_t'{pc: push_pc_i, instr: push_instr_i};
        wptr      <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven cycles checked against a scoreboard,
// plus hand-written bypass, flush and asynchronous-reset sequences.
module tb_fetch_queue;
  import defines::*;

  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush_i;
  logic                  push_valid_i;
  logic                  push_ready_o;
  logic [DATA_WIDTH-1:0] push_pc_i;
  logic [DATA_WIDTH-1:0] push_instr_i;
  logic                  pop_valid_o;
  logic                  pop_ready_i;
  logic [DATA_WIDTH-1:0] pop_pc_o;
  logic [DATA_WIDTH-1:0] pop_instr_o;
  logic [2:0]            count_o;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_entry_t sb[$];

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        pr;
    logic        fl;
    int          cnt;
  } vec_t;

  vec_t vecs[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .push_valid_i (push_valid_i),
    .push_ready_o (push_ready_o),
    .push_pc_i    (push_pc_i),
    .push_instr_i (push_instr_i),
    .pop_valid_o  (pop_valid_o),
    .pop_ready_i  (pop_ready_i),
    .pop_pc_o     (pop_pc_o),
    .pop_instr_o  (pop_instr_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h0000_0013 | (pc << 12);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one cycle, checks combinational outputs against the scoreboard, then advances.
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic pr, input logic fl);
    int           sz;
    logic         byp;
    logic         vld;
    fetch_entry_t ent;
    fetch_entry_t exp_head;
    ent          = '{pc: pc, instr: instr_of(pc)};
    push_valid_i = pv;
    push_pc_i    = pc;
    push_instr_i = ent.instr;
    pop_ready_i  = pr;
    flush_i      = fl;
    #1;
    sz  = sb.size();
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sz == 0) && pv && !fl;
`endif
    vld = (sz != 0) || byp;
    chk("push_ready", push_ready_o, sz != DEPTH);
    chk("pop_valid", pop_valid_o, vld);
    if (vld && pr && !fl) begin
      exp_head = byp ? ent : sb[0];
      chk("pop_pc", pop_pc_o, exp_head.pc);
      chk("pop_instr", pop_instr_o, exp_head.instr);
    end
    if (fl) begin
      sb.delete();
    end else if (!(byp && pr)) begin
      if ((sz != 0) && pr) void'(sb.pop_front());
      if (pv && (sz != DEPTH)) sb.push_back(ent);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic pv, input logic [31:0] pc, input logic pr, input logic fl,
                     input int cnt);
    vec_t v;
    v.pv = pv; v.pc = pc; v.pr = pr; v.fl = fl; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    rst          = 1'b1;
    flush_i      = 1'b0;
    push_valid_i = 1'b0;
    push_pc_i    = '0;
    push_instr_i = '0;
    pop_ready_i  = 1'b0;
    #2;
    chk("rst_count", count_o, 0);
    chk("rst_pop_valid", pop_valid_o, 0);
    chk("rst_push_ready", push_ready_o, 1);
    chk("rst_pop_pc", pop_pc_o, 0);
    chk("rst_pop_instr", pop_instr_o, 0);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill, hold a rejected 5th push, drain across pointer wrap, flush, redirect push.
    add(1, 32'h0, 0, 0, 1);
    add(1, 32'h4, 0, 0, 2);
    add(1, 32'h8, 0, 0, 3);
    add(1, 32'hC, 0, 0, 4);
    for (int i = 0; i < 3; i++) add(1, 32'h10, 0, 0, 4);
    add(1, 32'h10, 1, 0, 3);
    for (int k = 0; k < 10; k++) add(1, 32'h10 + 32'(4 * k), 1, 0, 3);
    add(1, 32'h100, 0, 1, 0);
    add(1, 32'h200, 0, 0, 1);
    add(0, 32'h0, 1, 0, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
    add(1, 32'h300, 1, 0, 0);
`else
    add(1, 32'h300, 1, 0, 1);
`endif
    add(0, 32'h0, 1, 0, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].pv, vecs[i].pc, vecs[i].pr, vecs[i].fl);
      chk($sformatf("row%0d_count", i), count_o, vecs[i].cnt);
      chk($sformatf("row%0d_ready", i), push_ready_o, vecs[i].cnt != DEPTH);
      chk($sformatf("row%0d_sb", i), count_o, sb.size());
    end

    // Push into an empty queue with decode ready.
    cycle(1, 32'h40, 1, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("bypass_count", count_o, 0);
`else
    chk("nobypass_count", count_o, 1);
    cycle(0, 32'h0, 1, 0);
    chk("nobypass_drain", count_o, 0);
`endif

    // Redirect while empty: no bypass, push discarded.
    cycle(1, 32'h50, 1, 1);
    chk("flush_empty_count", count_o, 0);

    // Asynchronous reset between edges with two entries buffered.
    cycle(1, 32'h60, 0, 0);
    cycle(1, 32'h64, 0, 0);
    chk("pre_rst_count", count_o, 2);
    push_valid_i = 1'b0;
    pop_ready_i  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_pop_valid", pop_valid_o, 0);
    chk("arst_push_ready", push_ready_o, 1);
    chk("arst_pop_pc", pop_pc_o, 0);
    chk("arst_pop_instr", pop_instr_o, 0);
    sb.delete();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_count", count_o, 0);
    cycle(1, 32'h70, 0, 0);
    chk("post_rst_push", count_o, 1);
    cycle(0, 32'h0, 1, 0);
    chk("post_rst_drain", count_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
